// File: rtl/hart_mem_arbiter_pkg.sv
// Shared definitions for the HART memory arbiter: grant-state encoding and
// the size code driven on the bus for instruction fetches.
package hart_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // Fetches are always full 32-bit words.
    localparam logic [2:0] FETCH_F3 = 3'b010;

endpackage

// File: rtl/hart_mem_arbiter_arb_watchdog.sv
// Transfer watchdog: counts grant cycles without bus completion and flags
// expiry when the count reaches TIMEOUT (TIMEOUT=0 never expires).
// Ports:
//   clk, rst  - clock, async active-high reset
//   clear     - hold counter at zero (no transfer in flight)
//   enable    - a transfer is granted this cycle
//   ready     - bus completed this cycle (wins over expiry)
//   expire_c  - combinational expiry pulse for the granted transfer
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic             at_limit;

    assign at_limit = (TIMEOUT != 0) && (count_q == LIMIT);
    assign expire_c = enable & ~ready & at_limit;

    // Wait counter; saturates at the limit so it never wraps into a false match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !ready && !at_limit) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the HART instruction
// fetch port and data port. A grant is held until the bus signals ready or
// the watchdog expires; bus payload is muxed live from the granted requester.
// Ports:
//   i_clk, i_rst                 - clock, async active-high reset
//   i_IC_DataReq, i_IM_Addr      - fetch request / address
//   o_IM_Instr, o_IC_MemReady    - fetch data / completion pulse
//   i_DM_MemRead, i_DM_Wen, i_DM_Addr, i_DM_WriteData, i_DM_f3 - data request
//   o_DM_ReadData, o_DM_data_ready - load data / completion pulse
//   o_BUS_*                      - granted transfer towards memory
//   i_BUS_ReadData, i_BUS_Ready  - memory response
//   o_err                        - watchdog termination pulse
module hart_mem_arbiter
    import hart_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_IC_DataReq,
    input  logic [ADDR_W-1:0] i_IM_Addr,
    output logic [DATA_W-1:0] o_IM_Instr,
    output logic              o_IC_MemReady,
    input  logic              i_DM_MemRead,
    input  logic              i_DM_Wen,
    input  logic [ADDR_W-1:0] i_DM_Addr,
    input  logic [DATA_W-1:0] i_DM_WriteData,
    input  logic [2:0]        i_DM_f3,
    output logic [DATA_W-1:0] o_DM_ReadData,
    output logic              o_DM_data_ready,
    output logic              o_BUS_Req,
    output logic              o_BUS_Wen,
    output logic [ADDR_W-1:0] o_BUS_Addr,
    output logic [DATA_W-1:0] o_BUS_WriteData,
    output logic [2:0]        o_BUS_f3,
    input  logic [DATA_W-1:0] i_BUS_ReadData,
    input  logic              i_BUS_Ready,
    output logic              o_err
);

    arb_state_t state_q, state_d;
    logic       last_data_q, last_data_d;   // 1: data port won the last grant
    logic       bus_req_q;
    logic       dm_req;
    logic       granted;
    logic       expire_c;
    logic       done;

    assign dm_req    = i_DM_MemRead | i_DM_Wen;
    assign granted   = (state_q != IDLE);
    assign done      = i_BUS_Ready | expire_c;
    assign o_BUS_Req = bus_req_q;
    assign o_err     = expire_c;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (!granted),
        .enable   (granted),
        .ready    (i_BUS_Ready),
        .expire_c (expire_c)
    );

    // State, fairness flag and registered bus request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b1;
            bus_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            bus_req_q   <= (state_d != IDLE);
        end
    end

    // Next-state, completion pulses and live bus mux.
    always_comb begin
        state_d         = state_q;
        last_data_d     = last_data_q;
        o_BUS_Wen       = 1'b0;
        o_BUS_Addr      = '0;
        o_BUS_WriteData = '0;
        o_BUS_f3        = '0;
        o_IM_Instr      = '0;
        o_DM_ReadData   = '0;
        o_IC_MemReady   = 1'b0;
        o_DM_data_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_IC_DataReq && dm_req) begin
                    state_d = last_data_q ? GNT_I : GNT_D;
                end else if (i_IC_DataReq) begin
                    state_d = GNT_I;
                end else if (dm_req) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                o_BUS_Addr    = i_IM_Addr;
                o_BUS_f3      = FETCH_F3;
                o_IC_MemReady = done;
                // A watchdog termination returns zero instead of bus data.
                if (!expire_c) begin
                    o_IM_Instr = i_BUS_ReadData;
                end
                if (done) begin
                    state_d     = IDLE;
                    last_data_d = 1'b0;
                end
            end
            GNT_D: begin
                o_BUS_Wen       = i_DM_Wen;
                o_BUS_Addr      = i_DM_Addr;
                o_BUS_WriteData = i_DM_WriteData;
                o_BUS_f3        = i_DM_f3;
                o_DM_data_ready = done;
                if (!expire_c) begin
                    o_DM_ReadData = i_BUS_ReadData;
                end
                if (done) begin
                    state_d     = IDLE;
                    last_data_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Scoreboard bench for hart_mem_arbiter (TIMEOUT=4): directed stimulus queues
// expected completions; a negedge monitor checks every ready pulse.
module tb_hart_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_IC_DataReq;
    logic [31:0] i_IM_Addr;
    logic [31:0] o_IM_Instr;
    logic        o_IC_MemReady;
    logic        i_DM_MemRead;
    logic        i_DM_Wen;
    logic [31:0] i_DM_Addr;
    logic [31:0] i_DM_WriteData;
    logic [2:0]  i_DM_f3;
    logic [31:0] o_DM_ReadData;
    logic        o_DM_data_ready;
    logic        o_BUS_Req;
    logic        o_BUS_Wen;
    logic [31:0] o_BUS_Addr;
    logic [31:0] o_BUS_WriteData;
    logic [2:0]  o_BUS_f3;
    logic [31:0] i_BUS_ReadData;
    logic        i_BUS_Ready;
    logic        o_err;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    hart_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_IC_DataReq    (i_IC_DataReq),
        .i_IM_Addr       (i_IM_Addr),
        .o_IM_Instr      (o_IM_Instr),
        .o_IC_MemReady   (o_IC_MemReady),
        .i_DM_MemRead    (i_DM_MemRead),
        .i_DM_Wen        (i_DM_Wen),
        .i_DM_Addr       (i_DM_Addr),
        .i_DM_WriteData  (i_DM_WriteData),
        .i_DM_f3         (i_DM_f3),
        .o_DM_ReadData   (o_DM_ReadData),
        .o_DM_data_ready (o_DM_data_ready),
        .o_BUS_Req       (o_BUS_Req),
        .o_BUS_Wen       (o_BUS_Wen),
        .o_BUS_Addr      (o_BUS_Addr),
        .o_BUS_WriteData (o_BUS_WriteData),
        .o_BUS_f3        (o_BUS_f3),
        .i_BUS_ReadData  (i_BUS_ReadData),
        .i_BUS_Ready     (i_BUS_Ready),
        .o_err           (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic [31:0] data, input logic err);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Called one step after the grant edge.
    task automatic expect_grant(input string name, input logic is_d, input logic [31:0] addr,
                                input logic wen, input logic [2:0] f3, input logic [31:0] wdata);
        check({name, " req"},   32'(o_BUS_Req), 32'(1));
        check({name, " addr"},  o_BUS_Addr, addr);
        check({name, " wen"},   32'(o_BUS_Wen), 32'(wen));
        check({name, " f3"},    32'(o_BUS_f3), 32'(f3));
        check({name, " wdata"}, o_BUS_WriteData, is_d ? wdata : 32'h0);
    endtask

    task automatic expect_idle(input string name);
        check({name, " req"},  32'(o_BUS_Req), 32'(0));
        check({name, " addr"}, o_BUS_Addr, 32'h0);
    endtask

    // Bus model: `delay` not-ready cycles, then one cycle with ready_at_end.
    task automatic serve(input int delay, input logic [31:0] rdata, input logic ready_at_end);
        i_BUS_ReadData = rdata;
        i_BUS_Ready    = 1'b0;
        repeat (delay) cyc();
        i_BUS_Ready = ready_at_end;
        cyc();
        i_BUS_Ready    = 1'b0;
        i_BUS_ReadData = 32'h0;
    endtask

    // Monitor: every completion pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_IC_MemReady || o_DM_data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: ic=%0b dm=%0b with empty scoreboard",
                             o_IC_MemReady, o_DM_data_ready);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ready_port", 32'({o_IC_MemReady, o_DM_data_ready}),
                          mon_e.is_d ? 32'h1 : 32'h2);
                    check("ready_data", mon_e.is_d ? o_DM_ReadData : o_IM_Instr, mon_e.data);
                    check("ready_err", 32'(o_err), 32'(mon_e.err));
                end
            end else if (o_err) begin
                checks++;
                errors++;
                $display("FAIL err_without_ready: o_err=1 got no ready pulse expected one");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        i_IC_DataReq   = 1'b0;
        i_IM_Addr      = 32'h0;
        i_DM_MemRead   = 1'b0;
        i_DM_Wen       = 1'b0;
        i_DM_Addr      = 32'h0;
        i_DM_WriteData = 32'h0;
        i_DM_f3        = 3'b000;
        i_BUS_ReadData = 32'h0;
        i_BUS_Ready    = 1'b0;

        // Reset values
        cyc();
        cyc();
        expect_idle("reset");
        check("reset ic_ready", 32'(o_IC_MemReady), 32'(0));
        check("reset dm_ready", 32'(o_DM_data_ready), 32'(0));
        check("reset err", 32'(o_err), 32'(0));
        check("reset f3", 32'(o_BUS_f3), 32'(0));
        rst = 1'b0;
        cyc();

        // Simultaneous requests: I, D, I, D with an idle cycle between
        i_IC_DataReq = 1'b1;
        i_IM_Addr    = 32'h200;
        i_DM_MemRead = 1'b1;
        i_DM_Addr    = 32'h8000;
        i_DM_f3      = 3'b010;
        cyc();
        expect_grant("both g1", 1'b0, 32'h200, 1'b0, 3'b010, 32'h0);
        push(1'b0, 32'hA000_0001, 1'b0);
        serve(0, 32'hA000_0001, 1'b1);
        expect_idle("both gap1");
        cyc();
        expect_grant("both g2", 1'b1, 32'h8000, 1'b0, 3'b010, 32'h0);
        push(1'b1, 32'hB000_0002, 1'b0);
        serve(1, 32'hB000_0002, 1'b1);
        expect_idle("both gap2");
        cyc();
        expect_grant("both g3", 1'b0, 32'h200, 1'b0, 3'b010, 32'h0);
        push(1'b0, 32'hA000_0003, 1'b0);
        serve(0, 32'hA000_0003, 1'b1);
        expect_idle("both gap3");
        cyc();
        expect_grant("both g4", 1'b1, 32'h8000, 1'b0, 3'b010, 32'h0);
        push(1'b1, 32'hB000_0004, 1'b0);
        serve(0, 32'hB000_0004, 1'b1);
        i_IC_DataReq = 1'b0;
        i_DM_MemRead = 1'b0;
        cyc();

        // Bus ready while idle is ignored
        i_BUS_Ready = 1'b1;
        check("idle ready ic", 32'(o_IC_MemReady), 32'(0));
        check("idle ready dm", 32'(o_DM_data_ready), 32'(0));
        cyc();
        i_BUS_Ready = 1'b0;

        // Fetch only, ready after 3 wait cycles
        i_IC_DataReq = 1'b1;
        i_IM_Addr    = 32'h100;
        expect_idle("fetch pre");
        cyc();
        expect_grant("fetch", 1'b0, 32'h100, 1'b0, 3'b010, 32'h0);
        push(1'b0, 32'h0000_0013, 1'b0);
        serve(3, 32'h0000_0013, 1'b1);
        i_IC_DataReq = 1'b0;
        expect_idle("fetch post");
        cyc();

        // Store
        i_DM_Wen       = 1'b1;
        i_DM_Addr      = 32'h8004;
        i_DM_WriteData = 32'hDEAD_BEEF;
        i_DM_f3        = 3'b010;
        cyc();
        expect_grant("store", 1'b1, 32'h8004, 1'b1, 3'b010, 32'hDEAD_BEEF);
        push(1'b1, 32'h0, 1'b0);
        serve(2, 32'h0, 1'b1);
        i_DM_Wen       = 1'b0;
        i_DM_WriteData = 32'h0;
        cyc();

        // Watchdog: bus never ready, expiry 4 cycles after grant with zero data
        i_DM_MemRead = 1'b1;
        i_DM_Addr    = 32'h8010;
        i_DM_f3      = 3'b100;
        cyc();
        expect_grant("wdog", 1'b1, 32'h8010, 1'b0, 3'b100, 32'h0);
        push(1'b1, 32'h0, 1'b1);
        serve(4, 32'h5555_5555, 1'b0);
        i_DM_MemRead = 1'b0;
        expect_idle("wdog post");
        // Next request proceeds normally
        i_IC_DataReq = 1'b1;
        i_IM_Addr    = 32'h300;
        cyc();
        expect_grant("after wdog", 1'b0, 32'h300, 1'b0, 3'b010, 32'h0);
        push(1'b0, 32'h0000_0013, 1'b0);
        serve(1, 32'h0000_0013, 1'b1);
        i_IC_DataReq = 1'b0;
        cyc();

        // Ready on the timeout cycle: normal completion
        i_DM_MemRead = 1'b1;
        i_DM_Addr    = 32'h8020;
        i_DM_f3      = 3'b010;
        cyc();
        expect_grant("edge", 1'b1, 32'h8020, 1'b0, 3'b010, 32'h0);
        push(1'b1, 32'hCAFE_F00D, 1'b0);
        serve(4, 32'hCAFE_F00D, 1'b1);
        i_DM_MemRead = 1'b0;
        cyc();

        // Reset mid-transfer, then fetch wins the first conflict
        i_DM_MemRead = 1'b1;
        i_DM_Addr    = 32'h8030;
        cyc();
        expect_grant("midrst", 1'b1, 32'h8030, 1'b0, 3'b010, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        expect_idle("midrst async");
        @(posedge clk);
        #1;
        rst          = 1'b0;
        i_IC_DataReq = 1'b1;
        i_IM_Addr    = 32'h400;
        cyc();
        expect_grant("postrst g1", 1'b0, 32'h400, 1'b0, 3'b010, 32'h0);
        push(1'b0, 32'h0000_0013, 1'b0);
        serve(0, 32'h0000_0013, 1'b1);
        cyc();
        expect_grant("postrst g2", 1'b1, 32'h8030, 1'b0, 3'b010, 32'h0);
        push(1'b1, 32'h1234_5678, 1'b0);
        serve(0, 32'h1234_5678, 1'b1);
        i_IC_DataReq = 1'b0;
        i_DM_MemRead = 1'b0;
        repeat (3) cyc();

        check("scoreboard empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hart_mem_arbiter.md
# hart_mem_arbiter

Two-requester arbiter that shares one memory bus between the HART's instruction-fetch port and its data-memory port. It sits between the HART and a single-ported memory or cache. It serialises fetches and loads/stores with round-robin fairness and holds each grant until the bus completes. A watchdog terminates any transfer the bus never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum wait cycles per transfer; 0 disables the watchdog
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_IC_DataReq  in  1  instruction fetch request, level, held until o_IC_MemReady
- i_IM_Addr  in  ADDR_W  fetch address, stable while requesting
- o_IM_Instr  out  DATA_W  fetched instruction, valid when o_IC_MemReady=1
- o_IC_MemReady  out  1  one-cycle fetch completion pulse
- i_DM_MemRead  in  1  load request, level
- i_DM_Wen  in  1  store request, level; i_DM_MemRead and i_DM_Wen are never both 1
- i_DM_Addr  in  ADDR_W  data address
- i_DM_WriteData  in  DATA_W  store data
- i_DM_f3  in  3  access size/sign code
- o_DM_ReadData  out  DATA_W  load data, valid when o_DM_data_ready=1
- o_DM_data_ready  out  1  one-cycle data completion pulse
- o_BUS_Req  out  1  bus request, registered
- o_BUS_Wen  out  1  write strobe for the granted transfer
- o_BUS_Addr  out  ADDR_W  granted address
- o_BUS_WriteData  out  DATA_W  granted store data
- o_BUS_f3  out  3  granted size code; 3'b010 for fetches
- i_BUS_ReadData  in  DATA_W  bus read data
- i_BUS_Ready  in  1  bus completion, one cycle per transfer
- o_err  out  1  one-cycle pulse when the watchdog terminates a transfer

## Operation
- States: IDLE, GNT_I, GNT_D.
- In IDLE with a single active request, grant that request.
- In IDLE with both requests active, grant the requester that did not win the last grant. The last-winner flag resets to "data", so instruction fetch wins first.
- A data request is i_DM_MemRead | i_DM_Wen.
- While in GNT_x:
  - o_BUS_Req=1.
  - Bus address, data, Wen and f3 are muxed combinationally from the granted requester's inputs. They are not latched.
  - Requesters keep their inputs stable until they see their ready pulse.
- o_IC_MemReady = (state==GNT_I) & i_BUS_Ready; o_DM_data_ready = (state==GNT_D) & i_BUS_Ready. Read data passes through.
- o_DM_ReadData is driven only in GNT_D and is 0 otherwise. o_IM_Instr follows the same rule in GNT_I.
- On i_BUS_Ready in GNT_x, return to IDLE and update the last-winner flag.
- Watchdog: a wait counter of width $clog2(TIMEOUT+1) clears on grant and increments each GNT cycle without i_BUS_Ready.
  - When it equals TIMEOUT, the block pulses o_err and pulses the granted requester's ready with read data forced to 0, then returns to IDLE.
  - i_BUS_Ready on the same cycle takes precedence: normal completion, no o_err.
- A requester that drops its request while granted violates the protocol. The grant holds regardless.

## Timing
- Reset values: state=IDLE, o_BUS_Req=0, o_IC_MemReady=0, o_DM_data_ready=0, o_err=0, counter=0. Bus address/data/Wen/f3 are 0 in IDLE.
- Request sampled in IDLE at cycle N gives o_BUS_Req=1 at cycle N+1.
- Ready pulse is in the same cycle as i_BUS_Ready, which is at the earliest cycle N+1.
- Back-to-back: one IDLE cycle between transfers, so a two-cycle minimum per transfer.
- i_BUS_Ready while in IDLE is ignored; no ready pulse is produced.
- Reset mid-transfer drops o_BUS_Req immediately (asynchronously). The bus slave tolerates the abandoned transfer.

## Structure
- The shared defines header holds the state encoding (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2) and the fetch f3 constant 3'b010.
- One sub-module, arb_watchdog: the counter, the terminal compare and the o_err generation. Inputs are clear/enable/ready; output is the expire pulse.
- Everything else is a single always block for the FSM plus combinational muxes.

## Test plan
- Fetch only: i_IC_DataReq=1, addr 0x100. o_BUS_Req rises next cycle with f3=010. Bus ready after 3 cycles with data 0x00000013 gives o_IC_MemReady pulse with o_IM_Instr=0x00000013.
- Simultaneous requests after reset: fetch 0x200 and load 0x8000 both held. Grants go I, then D, then I, then D, each with one IDLE cycle between.
- Store: i_DM_Wen=1, addr 0x8004, data 0xDEADBEEF, f3=010. Bus shows Wen=1 with the same values; ready gives o_DM_data_ready pulse.
- Watchdog: TIMEOUT=4 with the bus never ready. o_err and o_DM_data_ready pulse together 4 cycles after grant, with o_DM_ReadData=0; the next request proceeds normally.
- Ready on the timeout cycle: i_BUS_Ready coincides with the counter reaching TIMEOUT. Normal completion with real data and o_err=0.
- Reset mid-transfer: i_rst asserted during GNT_D. o_BUS_Req=0 in the same cycle, state is IDLE, and the first post-reset conflict grants fetch.
